// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 scan-code interpreter: prefix FSM with timeout, held-key bitmap for
// seven game keys, and a small press-event FIFO popped by the game FSM.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic [6:0] key_held,
    output logic       event_valid,
    output logic [2:0] event_key,
    input  logic       event_ack,
    output logic       event_overflow
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    held_q, held_d;
    logic          is_ext, is_brk;
    logic          mapped;
    logic [2:0]    key_idx;
    logic          push;
    logic [2:0]    push_key;

    assign is_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    assign is_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);

    // Arrow keys only exist behind E0; the same codes without it are keypad keys.
    always_comb begin
        mapped  = 1'b0;
        key_idx = 3'd0;
        if (is_ext) begin
            case (ps2_key_data)
                8'h75: begin mapped = 1'b1; key_idx = 3'd0; end
                8'h72: begin mapped = 1'b1; key_idx = 3'd1; end
                8'h6B: begin mapped = 1'b1; key_idx = 3'd2; end
                8'h74: begin mapped = 1'b1; key_idx = 3'd3; end
                default: ;
            endcase
        end else begin
            case (ps2_key_data)
                8'h1A: begin mapped = 1'b1; key_idx = 3'd4; end
                8'h22: begin mapped = 1'b1; key_idx = 3'd5; end
                8'h5A: begin mapped = 1'b1; key_idx = 3'd6; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        held_d   = held_q;
        push     = 1'b0;
        push_key = key_idx;
        if (ps2_key_pressed) begin
            cnt_d = '0;
            case (ps2_key_data)
                8'hE0:   state_d = S_EXT;
                8'hF0:   state_d = is_ext ? S_EXT_BRK : S_BRK;
                8'hE1:   state_d = S_IDLE;
                default: begin
                    state_d = S_IDLE;
                    if (mapped) begin
                        if (is_brk) begin
                            held_d[key_idx] = 1'b0;
                        end else begin
                            held_d[key_idx] = 1'b1;
                            push            = !held_q[key_idx];
                        end
                    end
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, rptr_q, count;
    logic [2:0]    head_q, head_d;
    logic          ovf_q;
    logic          empty, full, pop, wr;
    logic [AW-1:0] rd_nxt;

    assign count  = wptr_q - rptr_q;
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop    = event_ack && !empty;
    assign wr     = push && (!full || pop);
    assign rd_nxt = rptr_q[AW-1:0] + AW'(1);

    // head_q mirrors mem[rptr] so event_key is a clean register output.
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (count > (AW+1)'(1))
                head_d = mem_q[rd_nxt];
            else if (wr)
                head_d = push_key;
        end else if (wr && empty) begin
            head_d = push_key;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr)
            mem_q[wptr_q[AW-1:0]] <= push_key;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr)
                wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)
                rptr_q <= rptr_q + (AW+1)'(1);
            head_q <= head_d;
            if (push && full && !pop)
                ovf_q <= 1'b1;
        end
    end

    assign key_held       = held_q;
    assign event_valid    = !empty;
    assign event_key      = head_q;
    assign event_overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench: directed scenarios plus random byte streams against a
// prefix-flag / queue model of the key tracker.
module tb_ps2_key_tracker;
    localparam int T = 16;
    localparam int D = 4;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic       ps2_key_pressed = 1'b0;
    logic       event_ack = 1'b0;
    logic [6:0] key_held;
    logic       event_valid;
    logic [2:0] event_key;
    logic       event_overflow;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_key_tracker #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .ps2_key_data(ps2_key_data), .ps2_key_pressed(ps2_key_pressed),
        .key_held(key_held), .event_valid(event_valid), .event_key(event_key),
        .event_ack(event_ack), .event_overflow(event_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_ext, m_brk;
    int         m_since;
    logic [6:0] m_held;
    int         mq[$];
    bit         m_ovf;
    bit         m_pop;
    int         m_pk;

    function automatic int map_key(input bit ext, input logic [7:0] c);
        if (ext) begin
            case (c)
                8'h75: return 0;
                8'h72: return 1;
                8'h6B: return 2;
                8'h74: return 3;
                default: return -1;
            endcase
        end
        case (c)
            8'h1A: return 4;
            8'h22: return 5;
            8'h5A: return 6;
            default: return -1;
        endcase
    endfunction

    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            m_ext = 0; m_brk = 0; m_since = 0; m_held = '0; mq.delete(); m_ovf = 0;
        end else begin
            m_pop = event_ack && (mq.size() != 0);
            m_pk  = -1;
            if (ps2_key_pressed) begin
                m_since = 0;
                if (ps2_key_data == 8'hE0) begin
                    m_ext = 1; m_brk = 0;
                end else if (ps2_key_data == 8'hF0) begin
                    m_brk = 1;
                end else if (ps2_key_data == 8'hE1) begin
                    m_ext = 0; m_brk = 0;
                end else begin
                    m_pk = map_key(m_ext, ps2_key_data);
                    if (m_pk >= 0) begin
                        if (m_brk) begin
                            m_held[m_pk] = 1'b0;
                            m_pk = -1;
                        end else begin
                            if (m_held[m_pk]) m_pk = -1;
                            else m_held[m_pk] = 1'b1;
                        end
                    end
                    m_ext = 0; m_brk = 0;
                end
            end else begin
                m_since++;
                if ((m_ext || m_brk) && m_since >= T) begin
                    m_ext = 0; m_brk = 0;
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_pk >= 0) begin
                if (mq.size() == D) m_ovf = 1;
                else mq.push_back(m_pk);
            end
        end
    end

    // Compare process: a little after every falling edge, away from all input changes.
    always @(negedge CLOCK_50) begin
        #2;
        if (!resetn) begin
            chk("rst_held", key_held, 0);
            chk("rst_valid", event_valid, 0);
            chk("rst_key", event_key, 0);
            chk("rst_ovf", event_overflow, 0);
        end else begin
            chk("held", key_held, m_held);
            chk("valid", event_valid, mq.size() != 0);
            if (mq.size() != 0) chk("key", event_key, mq[0]);
            chk("ovf", event_overflow, m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        ps2_key_data = b; ps2_key_pressed = 1'b1; event_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            ps2_key_pressed = 1'b0; event_ack = 1'b0;
        end
    endtask

    task automatic look;
        idle(1);
        #3;
    endtask

    task automatic pop1;
        @(negedge CLOCK_50);
        ps2_key_pressed = 1'b0; event_ack = 1'b1;
    endtask

    task automatic do_reset;
        @(negedge CLOCK_50);
        resetn = 1'b0; ps2_key_pressed = 1'b0; event_ack = 1'b0;
        @(negedge CLOCK_50);
        #3;
        chk("lit_rst_held", key_held, 0);
        chk("lit_rst_valid", event_valid, 0);
        chk("lit_rst_ovf", event_overflow, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h72, 8'h6B,
                              8'h74, 8'h1A, 8'h22, 8'h5A, 8'h12, 8'h00};

    initial begin
        do_reset();

        // Z make, break
        send(8'h1A); look();
        chk("z_make_held", key_held, 7'h10);
        send(8'hF0); send(8'h1A); look();
        chk("z_brk_held", key_held, 7'h00);
        chk("z_valid", event_valid, 1);
        chk("z_key", event_key, 4);
        pop1(); look();
        chk("z_one_entry", event_valid, 0);

        // Up with typematic repeats, then extended break
        send(8'hE0); send(8'h75); send(8'h75); send(8'hE0); send(8'h75); look();
        chk("up_held", key_held, 7'h01);
        chk("up_key", event_key, 0);
        pop1(); look();
        chk("up_one_event", event_valid, 0);
        send(8'hE0); send(8'hF0); send(8'h75); look();
        chk("up_brk_held", key_held, 7'h00);
        chk("up_brk_noevt", event_valid, 0);

        // Keypad 75 is unmapped; timed-out E0 is forgotten
        send(8'h75); look();
        chk("kp_held", key_held, 7'h00);
        chk("kp_noevt", event_valid, 0);
        send(8'hE0); idle(T); send(8'h1A); look();
        chk("to_held", key_held, 7'h10);
        chk("to_key", event_key, 4);
        pop1(); send(8'hF0); send(8'h1A);
        // Strobe landing on the timeout cycle is still decoded as extended
        send(8'hE0); idle(T-1); send(8'h75); look();
        chk("to_edge_held", key_held, 7'h01);
        chk("to_edge_key", event_key, 0);
        pop1(); send(8'hE0); send(8'hF0); send(8'h75); look();
        chk("to_edge_rel", key_held, 7'h00);

        // Overflow then continuous drain
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h72);
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
        send(8'h1A); send(8'h22); look();
        chk("ovf_held", key_held, 7'h3F);
        chk("ovf_set", event_overflow, 1);
        chk("ovf_head", event_key, 0);
        @(negedge CLOCK_50); event_ack = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge CLOCK_50); #3;
            chk("drain_key", event_key, i);
        end
        @(negedge CLOCK_50); #3;
        chk("drain_empty", event_valid, 0);
        idle(1);
        do_reset();

        // Full FIFO, push and pop in the same cycle
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h72);
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); look();
        chk("full_head", event_key, 0);
        chk("full_noovf", event_overflow, 0);
        @(negedge CLOCK_50);
        ps2_key_data = 8'h1A; ps2_key_pressed = 1'b1; event_ack = 1'b1;
        @(negedge CLOCK_50);
        ps2_key_pressed = 1'b0;
        #3;
        chk("pp_noovf", event_overflow, 0);
        chk("pp_key1", event_key, 1);
        for (int i = 2; i < 5; i++) begin
            @(negedge CLOCK_50); #3;
            chk("pp_key", event_key, i);
        end
        @(negedge CLOCK_50); #3;
        chk("pp_empty", event_valid, 0);
        idle(1);
        do_reset();

        // Reset between E0 and 75
        send(8'hE0);
        @(negedge CLOCK_50);
        resetn = 1'b0; ps2_key_pressed = 1'b0;
        @(negedge CLOCK_50); #3;
        chk("mid_rst_held", key_held, 0);
        chk("mid_rst_valid", event_valid, 0);
        @(negedge CLOCK_50); resetn = 1'b1;
        send(8'h75); look();
        chk("mid_rst_noup", key_held, 0);
        chk("mid_rst_noevt", event_valid, 0);

        // Random streams
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLOCK_50);
            if ($urandom_range(0, 299) == 0) begin
                resetn = 1'b0;
                ps2_key_pressed = 1'b0;
                event_ack = 1'b0;
                @(negedge CLOCK_50);
                resetn = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                ps2_key_pressed = 1'b0;
                event_ack = 1'b0;
                idle($urandom_range(T-2, T+2));
            end else begin
                ps2_key_pressed = ($urandom_range(0, 99) < 45);
                ps2_key_data = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                                           : pool[$urandom_range(0, 11)];
                event_ack = ($urandom_range(0, 99) < 25);
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Scan-code interpreter and key-state scheduler between `PS2_Controller` and the game logic. It consumes the one-cycle received-byte strobe and decodes PS/2 Set-2 make/break sequences, including the `E0` and `F0` prefixes. It maintains a held-key bitmap for the seven game keys. It queues press events in a 4-entry FIFO that the game FSM pops with a ready/ack handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000 (20 ms at 50 MHz). A pending prefix with no follow-up byte within this many cycles is discarded.
- `FIFO_DEPTH`, default 4. Press-event queue depth; must be a power of two, ≥ 2.

Ports:
- `CLOCK_50`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ps2_key_data`  in  8  received byte; valid only when `ps2_key_pressed`=1.
- `ps2_key_pressed`  in  1  one-cycle strobe per received byte.
- `key_held`  out  7  bitmap: [0] Up, [1] Down, [2] Left, [3] Right, [4] Z, [5] X, [6] Enter.
- `event_valid`  out  1  FIFO non-empty; `event_key` is valid.
- `event_key`  out  3  key index (0–6) of the oldest unconsumed press.
- `event_ack`  in  1  pops the head when `event_valid`=1; ignored otherwise.
- `event_overflow`  out  1  sticky; set when a press is dropped because the FIFO is full.

## Operation
- Prefix FSM states are IDLE, EXT, BRK and EXT_BRK. The FSM advances only on strobe cycles, apart from the timeout below.
- Byte `E0`, from any state: go to EXT.
- Byte `F0`: IDLE→BRK, EXT→EXT_BRK; BRK and EXT_BRK stay where they are.
- Byte `E1`: go to IDLE; nothing is decoded.
- Any other byte is decoded in the current state, then the FSM returns to IDLE:
  - Extended states (EXT, EXT_BRK): `75` Up, `72` Down, `6B` Left, `74` Right.
  - Plain states (IDLE, BRK): `1A` Z, `22` X, `5A` Enter.
  - The same code in the wrong class is unmapped. Example: keypad `75` without `E0` is not Up.
- Make (IDLE or EXT) on a mapped key:
  - Sets its `key_held` bit.
  - If the bit was previously 0, pushes the key index into the FIFO.
  - Typematic repeats while held push nothing.
- Break (BRK or EXT_BRK) on a mapped key clears its `key_held` bit. Nothing is pushed.
- Unmapped codes change nothing except the FSM state.
- Timeout:
  - A counter clears on every strobe and increments while state ≠ IDLE.
  - When it reaches `TIMEOUT_CYCLES`-1, the FSM returns to IDLE.
  - If a strobe and the timeout fall on the same cycle, the strobe wins: the byte is decoded in the current state.
- FIFO:
  - Write and read pointers carry an extra wrap bit.
  - Push when full without a simultaneous pop: the event is dropped and `event_overflow` is set.
  - Push and pop in the same cycle when full: both occur; no overflow.
  - Pop when empty: ignored.

## Timing
- Reset values: state IDLE, counter 0, `key_held`=0, `event_valid`=0, `event_key`=0, `event_overflow`=0, FIFO empty.
- Reset asserted mid-sequence (for example, after `E0`) discards the prefix immediately and asynchronously.
- Strobe at edge N: `key_held` and FSM state update at edge N (visible in cycle N+1).
- A push into an empty FIFO raises `event_valid` in cycle N+1.
- `event_key` is the registered head entry. It changes only on a pop or on a push into an empty FIFO.
- Pop: `event_ack`=1 while `event_valid`=1 at edge M advances the head at M.
  - The next entry, or `event_valid`=0, is visible in cycle M+1.
  - The consumer may hold `event_ack` high continuously; this drains one entry per cycle.
- Back-to-back strobes on consecutive cycles must be handled. No bubble is required.
- The timeout return to IDLE occurs `TIMEOUT_CYCLES` cycles after the last strobe.

## Test plan
- Reset, then bytes `1A`, `F0`, `1A` → `key_held[4]` 1 after the first byte, 0 after the third. `event_valid`=1 with `event_key`=4; exactly one entry.
- Bytes `E0 75`, `75`, `E0 75` (repeats) → `key_held[0]`=1 and one event with key 0. Then `E0 F0 75` → `key_held[0]`=0 and no new event.
- Byte `75` alone (keypad) → `key_held`=0 and no event. Byte `E0`, idle for `TIMEOUT_CYCLES`, then `1A` → Z press is decoded (state returned to IDLE).
- Six distinct presses (Up, Down, Left, Right, Z, X) with no ack → first four are queued, `event_overflow`=1. Drain with `event_ack` held high → keys 0, 1, 2, 3 on consecutive cycles, then `event_valid`=0.
- FIFO full, a press strobe arrives in the same cycle as `event_ack` → no overflow, count stays 4, new key enters at the tail.
- Assert `resetn`=0 between `E0` and `75`, release, then send `75` → no Up press. All outputs at their reset values during reset.
